instr_fetch: RTL

- Upstream neighbour of the single-cycle datapath: holds the 256x8 program store and drives the datapath's 8-bit instruction input from the datapath's PC output.
- Programs are loaded byte-serially over a valid/ready port while the datapath is held in reset.
- Provides run/halt sequencing, an end-of-program halt, and an executed-instruction counter.
- Runs on the same divided clock as the datapath.

---
 rtl/instr_fetch_pkg.sv | 16 +
 rtl/instr_ram.sv | 22 ++
 rtl/instr_fetch.sv | 124 ++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared constants for the fetch stage: FSM encoding, bubble opcode, and
// the address/data widths it shares with the single-cycle datapath.
package instr_fetch_pkg;

  localparam int               DEF_ADDR_W = 8;
  localparam int               DEF_DATA_W = 8;
  localparam logic [7:0]       DEF_BUBBLE = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_ram.sv
// Program store: synchronous write, asynchronous read, contents survive reset.
module instr_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Combinational read so the datapath gets its opcode in the same cycle as pc.
  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: byte-serial program loader, run/halt sequencing of the datapath
// reset, end-of-program halt and a saturating executed-instruction counter.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W = DEF_ADDR_W,
  parameter int                DATA_W = DEF_DATA_W,
  parameter logic [DATA_W-1:0] BUBBLE = DEF_BUBBLE
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instruction,
  output logic              cpu_reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              load_done,
  input  logic              run,
  output logic              halted,
  output logic [ADDR_W:0]   prog_len,
  output logic [15:0]       instr_count
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [DATA_W-1:0] rd_data;
  logic              in_prog;
  logic              wr_en;

  // Compare at ADDR_W+1 bits so a full store never looks like "past the end".
  assign in_prog     = {1'b0, pc} < prog_len;
  assign wr_en       = (state == LOAD) && load_valid && load_ready && !load_start;
  assign instruction = (state == RUN && in_prog) ? rd_data : BUBBLE;

  instr_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk   (CLK),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (load_data),
    .raddr (pc),
    .rdata (rd_data)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      prog_len    <= '0;
      instr_count <= '0;
      cpu_reset   <= 1'b1;
      load_ready  <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            state      <= LOAD;
            wr_ptr     <= '0;
            prog_len   <= '0;
            load_ready <= 1'b1;
          end else if (run && prog_len != '0) begin
            // Datapath was held in reset throughout IDLE, so PC is already 0.
            state       <= RUN;
            instr_count <= '0;
            cpu_reset   <= 1'b0;
          end
        end
        LOAD: begin
          if (load_start) begin
            wr_ptr     <= '0;
            prog_len   <= '0;
            load_ready <= 1'b1;
          end else begin
            if (wr_en) begin
              wr_ptr   <= wr_ptr + 1'b1;
              prog_len <= prog_len + 1'b1;
            end
            // wr_ptr tracks prog_len, so all-ones here means this byte fills the store.
            if (load_done || (wr_en && wr_ptr == '1)) begin
              state      <= IDLE;
              load_ready <= 1'b0;
            end
          end
        end
        RUN: begin
          if (load_start) begin
            state      <= LOAD;
            cpu_reset  <= 1'b1;
            wr_ptr     <= '0;
            prog_len   <= '0;
            load_ready <= 1'b1;
          end else if (cpu_reset) begin
            // Restart cycle from HALT: pc is stale, so neither count nor halt.
            cpu_reset <= 1'b0;
          end else if (!in_prog) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (instr_count != '1) begin
            instr_count <= instr_count + 1'b1;
          end
        end
        HALT: begin
          if (load_start) begin
            state      <= LOAD;
            cpu_reset  <= 1'b1;
            halted     <= 1'b0;
            wr_ptr     <= '0;
            prog_len   <= '0;
            load_ready <= 1'b1;
          end else if (run) begin
            state       <= RUN;
            cpu_reset   <= 1'b1;
            instr_count <= '0;
            halted      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
